fetch_entry_queue: RTL and testbench
====================================

# fetch_entry_queue

Instruction buffer between the frontend and the ID stage. It accepts fetch entries (PC, raw instruction, branch prediction, fetch exception) from the frontend through a valid/ready handshake and stores them in a FIFO. It presents them in order to the ID stage as `fetch_entry_o` / `fetch_entry_valid_o`, retiring one entry each cycle that `fetch_entry_ready_i` is high. It is the transmitting end of the fetch-entry interface that the decode stage consumes. It also handles flushes and stops accepting entries after a faulting fetch.

## Interface
- `DEPTH`, default 4: number of entries; must be a power of two and at least 2.
- `clk_i` input 1: clock.
- `rst_ni` input 1: reset, synchronous, active-low.
- `flush_i` input 1: discard all stored entries and any entry arriving this cycle.
- `in_entry_i` input `ariane_pkg::fetch_entry_t`: entry from the frontend.
- `in_valid_i` input 1: `in_entry_i` is valid.
- `in_ready_o` output 1: the queue accepts `in_entry_i` this cycle.
- `fetch_entry_o` output `ariane_pkg::fetch_entry_t`: head entry sent to ID.
- `fetch_entry_valid_o` output 1: `fetch_entry_o` is valid.
- `fetch_entry_ready_i` input 1: ID consumes the head entry.
- `count_o` output $clog2(DEPTH)+1: number of stored entries.

## Operation
- **Storage:**
  - Circular buffer with read pointer, write pointer (both $clog2(DEPTH) bits, wrapping DEPTH-1 → 0) and a count register.
  - full = (count == DEPTH); empty = (count == 0).
- **Push:**
  - A push is `in_valid_i && in_ready_o`.
  - in_ready_o = !full && !ex_block_q && !flush_i.
  - A push writes the entry at the write pointer, then increments the write pointer.
- **Pop:**
  - A pop is `fetch_entry_valid_o && fetch_entry_ready_i`.
  - fetch_entry_valid_o = !empty && !flush_i (plus the bypass term in Configuration).
  - A pop increments the read pointer.
- **Count update:**
  - count += push − pop.
  - A simultaneous push and pop leaves count unchanged.
  - When full, the push is refused even if a pop happens in the same cycle. There is no full-queue pass-through.
- **Exception block (two-state FSM):**
  - States: OPEN and BLOCKED (`ex_block_q`).
  - OPEN → BLOCKED when an entry with `ex.valid = 1` is pushed.
  - BLOCKED → OPEN on `flush_i`.
  - While BLOCKED, in_ready_o = 0. Entries already stored, including the faulting one, still drain to ID normally.
- **Flush (highest priority):**
  - In the flush cycle: fetch_entry_valid_o = 0 and in_ready_o = 0, so no push or pop occurs.
  - At the next edge: pointers = 0, count = 0, FSM = OPEN.
- **Reset:**
  - Synchronous; applies at the clock edge while rst_ni = 0. It overrides flush, push and pop.
  - State after the edge: pointers 0, count 0, FSM OPEN.
- **Output values after a reset edge:** fetch_entry_valid_o = 0, in_ready_o = 1 (when in_valid_i and flush_i are low), count_o = 0.
- **Storage contents:** not reset. `fetch_entry_o` is don't-care while invalid.

## Timing
- Latency without bypass: an entry pushed at edge N is visible on `fetch_entry_o` in the cycle after edge N, if it is at the head.
- `fetch_entry_o` is driven directly from the storage at the read pointer. There is no combinational path from `fetch_entry_ready_i` to `fetch_entry_o`.
- `in_ready_o` depends only on registered state and `flush_i`. There is no path from `in_valid_i` or `fetch_entry_ready_i`.
- Throughput: one push and one pop per cycle sustained at any non-full, non-empty occupancy.
- `count_o` is registered and updates at the edge following a push or pop.
- Reset asserted mid-stream: all stored entries are lost. The first cycle after reset release behaves as empty and OPEN.

## Configuration
- Macro: `FETCH_QUEUE_BYPASS_EN`.
- **Defined:**
  - When empty, with `in_valid_i = 1`, `!flush_i` and `!ex_block_q`: fetch_entry_valid_o = 1 and fetch_entry_o = in_entry_i (combinational, zero latency).
  - If `fetch_entry_ready_i = 1` in that cycle, the entry is consumed without being written and count stays 0.
  - Otherwise the entry is written normally.
  - The exception FSM still transitions on a bypassed entry with ex.valid.
- **Not defined:**
  - There is no bypass path, and the minimum latency is 1 cycle.
  - fetch_entry_valid_o is never high while count = 0.

## Test plan
- **Fill and drain:** DEPTH=4, ready_i = 0, push PCs 0x80, 0x84, 0x88, 0x8C.
  - Expect count_o = 4 and in_ready_o = 0 on the fifth attempt.
  - Then ready_i = 1: expect the output sequence 0x80, 0x84, 0x88, 0x8C on consecutive cycles, then valid = 0.
- **Full with pop:** at count = 4, push 0x90 with ready_i = 1.
  - Expect 0x90 refused and count = 3.
  - Next cycle 0x90 is accepted and count = 4.
- **Wrap-around:** 10 pushes, each popped 2 cycles later.
  - Expect in-order output 0x100…0x124.
  - Expect count never above 2 and the pointers wrap with no loss.
- **Exception block:** push 0x200 with ex.valid = 1, then offer 0x204.
  - Expect in_ready_o = 0 and only 0x200 delivered, with ex.valid set.
  - Flush: expect in_ready_o = 1 the cycle after, and 0x204 accepted.
- **Flush with simultaneous push and pop:** count = 3, in_valid = 1, ready_i = 1, flush_i = 1.
  - Expect valid_o = 0 and in_ready_o = 0 during the flush cycle.
  - Next cycle count = 0 and valid_o = 0.
- **Bypass:** empty, push 0x300 with ready_i = 1.
  - With FETCH_QUEUE_BYPASS_EN: valid_o = 1 the same cycle with PC 0x300, count stays 0.
  - Without it: 0x300 appears 1 cycle later, count = 1 in between.

Source files
------------

// File: rtl/fetch_entry_queue.sv
// fetch_entry_queue: instruction buffer between the frontend and the ID stage.
// Entries from the frontend are stored in a circular buffer and presented in
// order to ID. A fetch carrying an exception blocks further pushes until the
// next flush. The faulting entry and everything before it still drain to ID.
//
// Optional feature: define FETCH_QUEUE_BYPASS_EN to forward an incoming entry
// straight to ID when the queue is empty (zero-latency path).
//
// Ports:
//   clk_i               clock
//   rst_ni              synchronous active-low reset
//   flush_i             drop all stored entries and the entry arriving this cycle
//   in_entry_i          fetch entry from the frontend
//   in_valid_i          in_entry_i is valid
//   in_ready_o          queue accepts in_entry_i this cycle
//   fetch_entry_o       head entry towards ID
//   fetch_entry_valid_o fetch_entry_o is valid
//   fetch_entry_ready_i ID consumes the head entry
//   count_o             number of stored entries

package ariane_pkg;
  typedef enum logic [2:0] {NoCF, Branch, Jump, JumpR, Return} cf_t;

  typedef struct packed {
    cf_t         cf;
    logic [63:0] predict_address;
  } branchpredict_sbe_t;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic [63:0]        address;
    logic [31:0]        instruction;
    branchpredict_sbe_t branch_predict;
    exception_t         ex;
  } fetch_entry_t;
endpackage

module fetch_entry_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  ariane_pkg::fetch_entry_t in_entry_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  output ariane_pkg::fetch_entry_t fetch_entry_o,
  output logic                     fetch_entry_valid_o,
  input  logic                     fetch_entry_ready_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {OPEN, BLOCKED} ex_state_e;

  ex_state_e                state_q, state_d;
  logic                     ex_block_q;

  ariane_pkg::fetch_entry_t mem_q [DEPTH];
  logic [PTR_W-1:0]         rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]         count_q;

  logic                     full, empty;
  logic                     push;
  logic                     wr_en, rd_en;
`ifdef FETCH_QUEUE_BYPASS_EN
  logic                     bypass;
`endif

  // Handshake and storage control
  always_comb begin
    full       = (count_q == CNT_W'(DEPTH));
    empty      = (count_q == '0);
    // No pass-through when full: a same-cycle pop does not free a slot.
    in_ready_o = !full && !ex_block_q && !flush_i;
    push       = in_valid_i && in_ready_o;
`ifdef FETCH_QUEUE_BYPASS_EN
    // When empty, push already implies !flush_i and !ex_block_q.
    bypass              = empty && push;
    fetch_entry_valid_o = (!empty && !flush_i) || bypass;
    fetch_entry_o       = bypass ? in_entry_i : mem_q[rd_ptr_q];
    // A bypassed entry consumed in the same cycle never touches storage.
    wr_en               = push && !(bypass && fetch_entry_ready_i);
    rd_en               = fetch_entry_valid_o && fetch_entry_ready_i && !bypass;
`else
    fetch_entry_valid_o = !empty && !flush_i;
    fetch_entry_o       = mem_q[rd_ptr_q];
    wr_en               = push;
    rd_en               = fetch_entry_valid_o && fetch_entry_ready_i;
`endif
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage, intentionally not reset
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= in_entry_i;
  end

  // Exception block FSM: state register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= OPEN;
    else         state_q <= state_d;
  end

  // Exception block FSM: next state
  always_comb begin
    state_d = state_q;
    if (flush_i)
      state_d = OPEN;
    else if (state_q == OPEN && push && in_entry_i.ex.valid)
      state_d = BLOCKED;
  end

  // Exception block FSM: outputs
  always_comb begin
    ex_block_q = (state_q == BLOCKED);
  end

  assign count_o = count_q;

endmodule

// File: tb/tb_fetch_entry_queue.sv
// Bench for fetch_entry_queue: table of vectors plus hand-written sequences,
// all cross-checked against a queue-based reference model every cycle.
module tb_fetch_entry_queue;
  import ariane_pkg::*;

  localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic                   out_valid;
  logic                   out_ready;
  fetch_entry_t           in_entry;
  fetch_entry_t           out_entry;
  logic [$clog2(DEPTH):0] count;

  always #5 clk = ~clk;

  fetch_entry_queue #(.DEPTH(DEPTH)) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .flush_i             (flush),
    .in_entry_i          (in_entry),
    .in_valid_i          (in_valid),
    .in_ready_o          (in_ready),
    .fetch_entry_o       (out_entry),
    .fetch_entry_valid_o (out_valid),
    .fetch_entry_ready_i (out_ready)
    ,.count_o            (count)
  );

  typedef struct {
    logic [63:0] pc;
    logic        exv;
  } m_t;

  typedef struct {
    logic        fl;
    logic        vin;
    logic [63:0] pc;
    logic        rdy;
    int          e_cnt;
    logic        e_rdy;
    logic        e_vld;
    logic [63:0] e_pc;
  } vec_t;

  m_t          mq[$];
  logic        m_block;
  int          n_pass  = 0;
  int          n_total = 0;

  logic [63:0] s_count;
  logic        s_in_ready;
  logic        s_valid;
  logic [63:0] s_pc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Drives one cycle of stimulus, checks DUT against the model before the
  // edge, then advances the model across the edge.
  task automatic cycle(input logic fl, input logic vin, input logic [63:0] pc,
                       input logic exv, input logic rdy);
    int          sz;
    logic        byp;
    logic        e_in_rdy;
    logic        e_valid;
    logic [63:0] e_pc;
    logic        e_exv;
    logic        do_push;
    logic        do_pop;
    m_t          m;

    flush                = fl;
    in_valid             = vin;
    in_entry             = '0;
    in_entry.address     = pc;
    in_entry.instruction = pc[31:0] ^ 32'h13;
    in_entry.ex.valid    = exv;
    out_ready            = rdy;
    #2;
    sz       = mq.size();
    byp      = BYP && (sz == 0) && vin && !fl && !m_block;
    e_in_rdy = (sz < DEPTH) && !m_block && !fl;
    e_valid  = (sz > 0 && !fl) || byp;
    chk("in_ready", in_ready, e_in_rdy);
    chk("valid", out_valid, e_valid);
    chk("count", count, sz);
    if (e_valid) begin
      e_pc  = byp ? pc  : mq[0].pc;
      e_exv = byp ? exv : mq[0].exv;
      chk("head_pc", out_entry.address, e_pc);
      chk("head_instr", out_entry.instruction, e_pc[31:0] ^ 32'h13);
      chk("head_ex", out_entry.ex.valid, e_exv);
    end
    s_count    = count;
    s_in_ready = in_ready;
    s_valid    = out_valid;
    s_pc       = out_entry.address;
    @(posedge clk);
    if (!rst_n || fl) begin
      mq.delete();
      m_block = 1'b0;
    end else begin
      do_push = vin && e_in_rdy;
      do_pop  = e_valid && rdy;
      if (!(byp && rdy)) begin
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
          m.pc  = pc;
          m.exv = exv;
          mq.push_back(m);
        end
      end
      if (do_push && exv) m_block = 1'b1;
    end
    #1;
  endtask

  vec_t tbl[12];
  int   k;

  initial begin
    // fill / refuse-when-full / full-with-pop / drain
    tbl[0]  = '{1'b0, 1'b1, 64'h80, 1'b0, 0, 1'b1, BYP,  64'h80};
    tbl[1]  = '{1'b0, 1'b1, 64'h84, 1'b0, 1, 1'b1, 1'b1, 64'h80};
    tbl[2]  = '{1'b0, 1'b1, 64'h88, 1'b0, 2, 1'b1, 1'b1, 64'h80};
    tbl[3]  = '{1'b0, 1'b1, 64'h8C, 1'b0, 3, 1'b1, 1'b1, 64'h80};
    tbl[4]  = '{1'b0, 1'b1, 64'h90, 1'b0, 4, 1'b0, 1'b1, 64'h80};
    tbl[5]  = '{1'b0, 1'b1, 64'h90, 1'b1, 4, 1'b0, 1'b1, 64'h80};
    tbl[6]  = '{1'b0, 1'b1, 64'h90, 1'b0, 3, 1'b1, 1'b1, 64'h84};
    tbl[7]  = '{1'b0, 1'b0, 64'h0,  1'b1, 4, 1'b0, 1'b1, 64'h84};
    tbl[8]  = '{1'b0, 1'b0, 64'h0,  1'b1, 3, 1'b1, 1'b1, 64'h88};
    tbl[9]  = '{1'b0, 1'b0, 64'h0,  1'b1, 2, 1'b1, 1'b1, 64'h8C};
    tbl[10] = '{1'b0, 1'b0, 64'h0,  1'b1, 1, 1'b1, 1'b1, 64'h90};
    tbl[11] = '{1'b0, 1'b0, 64'h0,  1'b0, 0, 1'b1, 1'b0, 64'h0};

    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_entry  = '0;
    m_block   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // state right after reset
    cycle(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    chk("rst_count", s_count, 64'd0);
    chk("rst_valid", s_valid, 1'b0);
    chk("rst_in_ready", s_in_ready, 1'b1);

    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].fl, tbl[i].vin, tbl[i].pc, 1'b0, tbl[i].rdy);
      chk($sformatf("tbl%0d_count", i), s_count, tbl[i].e_cnt);
      chk($sformatf("tbl%0d_in_ready", i), s_in_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_valid", i), s_valid, tbl[i].e_vld);
      if (tbl[i].e_vld) chk($sformatf("tbl%0d_pc", i), s_pc, tbl[i].e_pc);
    end

    // wrap-around: each entry popped two cycles after its push
    k = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, i < 10, 64'h100 + 64'(4 * i), 1'b0, i >= 2);
      chk("wrap_cnt_le2", s_count <= 2, 1'b1);
      if (s_valid && i >= 2) begin
        chk("wrap_pc", s_pc, 64'h100 + 64'(4 * k));
        k++;
      end
    end
    chk("wrap_pops", k, 10);

    // exception block
    cycle(1'b0, 1'b1, 64'h200, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 64'h204, 1'b0, 1'b0);
    chk("exc_blocked", s_in_ready, 1'b0);
    cycle(1'b0, 1'b1, 64'h204, 1'b0, 1'b1);
    chk("exc_head", s_pc, 64'h200);
    chk("exc_head_exv", dut.fetch_entry_o.ex.valid | s_valid, 1'b1);
    cycle(1'b0, 1'b1, 64'h204, 1'b0, 1'b1);
    chk("exc_drained_valid", s_valid, 1'b0);
    chk("exc_still_blocked", s_in_ready, 1'b0);
    cycle(1'b1, 1'b1, 64'h204, 1'b0, 1'b0);
    chk("exc_flush_in_ready", s_in_ready, 1'b0);
    cycle(1'b0, 1'b1, 64'h204, 1'b0, 1'b0);
    chk("exc_reopen", s_in_ready, 1'b1);
    cycle(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
    chk("exc_after_pc", s_pc, 64'h204);

    // flush with simultaneous push and pop
    cycle(1'b0, 1'b1, 64'h400, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 64'h404, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 64'h408, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 64'h40C, 1'b0, 1'b1);
    chk("fl_count_before", s_count, 64'd3);
    chk("fl_valid", s_valid, 1'b0);
    chk("fl_in_ready", s_in_ready, 1'b0);
    cycle(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    chk("fl_count_after", s_count, 64'd0);
    chk("fl_valid_after", s_valid, 1'b0);

    // bypass / minimum latency
    cycle(1'b0, 1'b1, 64'h300, 1'b0, 1'b1);
    chk("byp_valid_same_cycle", s_valid, BYP);
    cycle(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    chk("byp_count_next", s_count, BYP ? 64'd0 : 64'd1);
    chk("byp_valid_next", s_valid, !BYP);
    cycle(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);

    // reset mid-stream
    cycle(1'b0, 1'b1, 64'h500, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 64'h504, 1'b0, 1'b0);
    rst_n = 1'b0;
    cycle(1'b0, 1'b1, 64'h508, 1'b0, 1'b1);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    chk("mrst_count", s_count, 64'd0);
    chk("mrst_valid", s_valid, 1'b0);
    chk("mrst_in_ready", s_in_ready, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
